// File: rtl/regfile_multiport.sv
`default_nettype none
// ============================================================================
// Module   : regfile_multiport
// Purpose  : Multi-read-port register file with an init sweep after reset,
//            write-to-read forwarding, pending-result scoreboard, debug read.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_multiport #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 5,
    parameter int                    NUM_READ   = 2,
    parameter int                    BYPASS     = 1,
    parameter int                    SP_INDEX   = 2,
    parameter logic [DATA_WIDTH-1:0] SP_INIT    = 32'h1000_3FFC
) (
    input  logic                           iCLK,
    input  logic                           iRST_N,
    input  logic                           iWriteEn,
    input  logic [ADDR_WIDTH-1:0]          iWriteAddr,
    input  logic [DATA_WIDTH-1:0]          iWriteData,
    input  logic                           iReserve,
    input  logic [ADDR_WIDTH-1:0]          iReserveAddr,
    input  logic [NUM_READ*ADDR_WIDTH-1:0] iReadAddr,
    output logic [NUM_READ*DATA_WIDTH-1:0] oReadData,
    output logic [NUM_READ-1:0]            oReadBusy,
    input  logic [ADDR_WIDTH-1:0]          iDispSelect,
    output logic [DATA_WIDTH-1:0]          oDisp,
    output logic                           oReady
);

    localparam int                    c_depth   = 2**ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] c_last    = '1;
    localparam logic [ADDR_WIDTH-1:0] c_sp_addr = ADDR_WIDTH'(SP_INDEX);

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_cnt;
    logic                  r_ready;
    logic [DATA_WIDTH-1:0] r_disp;
    logic [c_depth-1:0]    r_pend;
    logic [DATA_WIDTH-1:0] r_mem [c_depth];

    logic w_run;
    logic w_wr_valid;
    logic w_rsv_valid;

    assign w_run       = (r_state == ST_RUN);
    assign w_wr_valid  = w_run && iWriteEn && (iWriteAddr != '0);
    assign w_rsv_valid = w_run && iReserve && (iReserveAddr != '0);

    always_ff @(posedge iCLK) begin
        if (!iRST_N) begin
            r_state <= ST_INIT;
            r_cnt   <= '0;
            r_ready <= 1'b0;
            r_disp  <= '0;
            r_pend  <= '0;
        end else begin
            case (r_state)
                ST_INIT: begin
                    r_cnt  <= r_cnt + 1'b1;
                    r_disp <= '0;
                    r_pend <= '0;
                    if (r_cnt == c_last) begin
                        r_state <= ST_RUN;
                        r_ready <= 1'b1;
                    end
                end
                ST_RUN: begin
                    r_disp <= r_mem[iDispSelect];
                    if (w_wr_valid)
                        r_pend[iWriteAddr] <= 1'b0;
                    // Reserve is applied last so it wins over a same-index write
                    if (w_rsv_valid)
                        r_pend[iReserveAddr] <= 1'b1;
                end
                default: r_state <= ST_INIT;
            endcase
        end
    end

    // Storage is not cleared by reset; the sweep that follows rewrites it
    always_ff @(posedge iCLK) begin
        if (iRST_N) begin
            if (r_state == ST_INIT)
                r_mem[r_cnt] <= (r_cnt == c_sp_addr) ? SP_INIT : '0;
            else if (w_wr_valid)
                r_mem[iWriteAddr] <= iWriteData;
        end
    end

    for (genvar p = 0; p < NUM_READ; p++) begin : g_rd
        logic [ADDR_WIDTH-1:0] w_addr;
        logic                  w_fwd;

        assign w_addr = iReadAddr[p*ADDR_WIDTH +: ADDR_WIDTH];
        assign w_fwd  = (BYPASS != 0) && w_wr_valid && (iWriteAddr == w_addr);

        assign oReadData[p*DATA_WIDTH +: DATA_WIDTH] =
            (!w_run || (w_addr == '0)) ? '0 :
            w_fwd                      ? iWriteData :
                                         r_mem[w_addr];
        assign oReadBusy[p] = w_run && (w_addr != '0) && !w_fwd && r_pend[w_addr];
    end

    assign oReady = r_ready;
    assign oDisp  = r_disp;

endmodule
`default_nettype wire

// File: tb/tb_regfile_multiport.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_multiport
// Purpose  : Bench for regfile_multiport; BYPASS=1 and BYPASS=0 copies driven
//            in parallel and compared to an array-based model every cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_multiport;

    localparam int c_nr = 3;

    logic        clk;
    logic        rst_n;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        rsv;
    logic [4:0]  ra;
    logic [14:0] raddr;
    logic [4:0]  dsel;

    logic [95:0] rd_b, rd_n;
    logic [2:0]  busy_b, busy_n;
    logic [31:0] disp_b, disp_n;
    logic        rdy_b, rdy_n;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 0;

    regfile_multiport #(.NUM_READ(c_nr), .BYPASS(1)) dut_b (
        .iCLK(clk), .iRST_N(rst_n), .iWriteEn(we), .iWriteAddr(wa), .iWriteData(wd),
        .iReserve(rsv), .iReserveAddr(ra), .iReadAddr(raddr), .oReadData(rd_b),
        .oReadBusy(busy_b), .iDispSelect(dsel), .oDisp(disp_b), .oReady(rdy_b)
    );

    regfile_multiport #(.NUM_READ(c_nr), .BYPASS(0)) dut_n (
        .iCLK(clk), .iRST_N(rst_n), .iWriteEn(we), .iWriteAddr(wa), .iWriteData(wd),
        .iReserve(rsv), .iReserveAddr(ra), .iReadAddr(raddr), .oReadData(rd_n),
        .oReadBusy(busy_n), .iDispSelect(dsel), .oDisp(disp_n), .oReady(rdy_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: plain arrays plus a sweep position
    logic [31:0] m_mem [32];
    bit          m_pend [32];
    bit          m_run;
    int          m_cnt;
    logic [31:0] m_disp;

    initial begin
        for (int i = 0; i < 32; i++) begin
            m_mem[i]  = '0;
            m_pend[i] = 0;
        end
        m_run  = 0;
        m_cnt  = 0;
        m_disp = '0;
    end

    always @(posedge clk) begin
        if (rst_n !== 1'b1) begin
            m_run  = 0;
            m_cnt  = 0;
            m_disp = '0;
            for (int i = 0; i < 32; i++) m_pend[i] = 0;
        end else if (!m_run) begin
            m_disp        = '0;
            m_mem[m_cnt]  = (m_cnt == 2) ? 32'h1000_3FFC : 32'h0;
            if (m_cnt == 31) m_run = 1;
            m_cnt = m_cnt + 1;
        end else begin
            m_disp = m_mem[dsel];
            if (we && wa != 0) begin
                m_mem[wa]  = wd;
                m_pend[wa] = 0;
            end
            if (rsv && ra != 0) m_pend[ra] = 1;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            bit          wv;
            logic [4:0]  a;
            logic [31:0] e_b, e_n;
            bit          eb_b, eb_n;
            wv = m_run && we && (wa != 0);
            chk("ready_b", {31'b0, rdy_b}, {31'b0, m_run});
            chk("ready_n", {31'b0, rdy_n}, {31'b0, m_run});
            chk("disp_b", disp_b, m_disp);
            chk("disp_n", disp_n, m_disp);
            for (int p = 0; p < c_nr; p++) begin
                a = raddr[p*5 +: 5];
                if (!m_run || a == 0) begin
                    e_b = '0; e_n = '0; eb_b = 0; eb_n = 0;
                end else begin
                    e_n  = m_mem[a];
                    eb_n = m_pend[a];
                    e_b  = (wv && wa == a) ? wd : m_mem[a];
                    eb_b = (wv && wa == a) ? 1'b0 : m_pend[a];
                end
                chk("rdata_b", rd_b[p*32 +: 32], e_b);
                chk("rdata_n", rd_n[p*32 +: 32], e_n);
                chk("busy_b", {31'b0, busy_b[p]}, {31'b0, eb_b});
                chk("busy_n", {31'b0, busy_n[p]}, {31'b0, eb_n});
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_rd(input int p, input logic [4:0] a);
        raddr[p*5 +: 5] = a;
    endtask

    task automatic sweep_len(input string nm);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (!rdy_b && n < 40);
        chk(nm, n, 32);
    endtask

    initial begin
        rst_n = 1'b0; we = 0; wa = '0; wd = '0; rsv = 0; ra = '0; raddr = '0; dsel = '0;
        repeat (3) tick();
        cmp_en = 1;
        #1;
        chk("rst_ready", {31'b0, rdy_b}, 32'h0);
        chk("rst_disp", disp_b, 32'h0);

        rst_n = 1'b1;
        sweep_len("sweep_len");

        set_rd(0, 5'd2); set_rd(1, 5'd5); set_rd(2, 5'd31);
        #1;
        chk("sp_init", rd_b[31:0], 32'h1000_3FFC);
        chk("zero_init5", rd_b[63:32], 32'h0);
        chk("zero_init31", rd_n[95:64], 32'h0);

        set_rd(0, 5'd5);
        we = 1; wa = 5'd5; wd = 32'hDEAD_BEEF;
        #1;
        chk("bypass_same", rd_b[31:0], 32'hDEAD_BEEF);
        chk("nobypass_old", rd_n[31:0], 32'h0);
        tick();
        we = 0;
        #1;
        chk("nobypass_next", rd_n[31:0], 32'hDEAD_BEEF);

        set_rd(0, 5'd0);
        we = 1; wa = 5'd0; wd = 32'hFFFF_FFFF; rsv = 1; ra = 5'd0;
        #1;
        chk("r0_data", rd_b[31:0], 32'h0);
        chk("r0_busy", {31'b0, busy_b[0]}, 32'h0);
        tick();
        we = 0; rsv = 0;
        #1;
        chk("r0_after", rd_n[31:0], 32'h0);
        chk("r0_busy_after", {31'b0, busy_n[0]}, 32'h0);

        rsv = 1; ra = 5'd7;
        tick();
        rsv = 0; set_rd(0, 5'd7);
        #1;
        chk("rsv7_busy", {31'b0, busy_b[0]}, 32'h1);
        we = 1; wa = 5'd7; wd = 32'h55;
        #1;
        chk("rsv7_fwd_busy", {31'b0, busy_b[0]}, 32'h0);
        chk("rsv7_nofwd_busy", {31'b0, busy_n[0]}, 32'h1);
        tick();
        we = 0;
        #1;
        chk("wr7_clears", {31'b0, busy_n[0]}, 32'h0);
        rsv = 1; ra = 5'd7; we = 1; wa = 5'd7; wd = 32'h55;
        tick();
        rsv = 0; we = 0;
        #1;
        chk("rsv_wins_busy", {31'b0, busy_b[0]}, 32'h1);
        chk("rsv_wins_data", rd_n[31:0], 32'h55);

        set_rd(0, 5'd9); set_rd(1, 5'd9); set_rd(2, 5'd9);
        we = 1; wa = 5'd9; wd = 32'hA5A5_0009; dsel = 5'd9;
        #1;
        chk("all9_p0", rd_b[31:0], 32'hA5A5_0009);
        chk("all9_p1", rd_b[63:32], 32'hA5A5_0009);
        chk("all9_p2", rd_b[95:64], 32'hA5A5_0009);
        tick();
        we = 0;
        tick();
        chk("disp9", disp_b, 32'hA5A5_0009);

        rst_n = 1'b0;
        tick();
        chk("rst_run_ready", {31'b0, rdy_b}, 32'h0);
        rst_n = 1'b1;
        repeat (10) tick();
        rst_n = 1'b0;
        tick();
        chk("rst_mid_ready", {31'b0, rdy_b}, 32'h0);
        rst_n = 1'b1;
        sweep_len("resweep_len");

        for (int i = 0; i < 2000; i++) begin
            rst_n = ($urandom_range(0, 599) != 0);
            we    = $urandom_range(0, 1);
            wa    = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
            wd    = $urandom;
            rsv   = ($urandom_range(0, 3) == 0);
            ra    = 5'($urandom_range(0, 7));
            for (int p = 0; p < c_nr; p++) set_rd(p, 5'($urandom_range(0, 7)));
            dsel  = 5'($urandom_range(0, 31));
            tick();
        end

        rst_n = 1'b1; we = 0; rsv = 0;
        repeat (2) tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/regfile_multiport.md
REGFILE_MULTIPORT -- requirements
Module: regfile_multiport

Interface
REQ-001 Parameter DATA_WIDTH, default 32, register width in bits.
REQ-002 Parameter ADDR_WIDTH, default 5, register index width; depth is 2^ADDR_WIDTH.
REQ-003 Parameter NUM_READ, default 2, number of independent read ports (1..4).
REQ-004 Parameter BYPASS, default 1, enables same-cycle write-to-read forwarding.
REQ-005 Parameter SP_INDEX, default 2, index given a non-zero init value.
REQ-006 Parameter SP_INIT, default 32'h1000_3FFC, init value of register SP_INDEX.
REQ-007 iCLK  input  1  sole clock; all state updates on rising edge.
REQ-008 iRST_N  input  1  reset, synchronous, active-low.
REQ-009 iWriteEn  input  1  write strobe.
REQ-010 iWriteAddr  input  ADDR_WIDTH  write index.
REQ-011 iWriteData  input  DATA_WIDTH  write data.
REQ-012 iReserve  input  1  marks iReserveAddr as pending (result in flight).
REQ-013 iReserveAddr  input  ADDR_WIDTH  index to reserve.
REQ-014 iReadAddr  input  NUM_READ*ADDR_WIDTH  packed read indices, port p at bits [p*ADDR_WIDTH +: ADDR_WIDTH].
REQ-015 oReadData  output  NUM_READ*DATA_WIDTH  packed read data, same packing.
REQ-016 oReadBusy  output  NUM_READ  per port: addressed register is pending.
REQ-017 iDispSelect  input  ADDR_WIDTH  debug/display index.
REQ-018 oDisp  output  DATA_WIDTH  registered debug value, one-cycle latency.
REQ-019 oReady  output  1  high when init sweep is done and the file accepts operations.

Function
REQ-020 State machine SHALL have two states: INIT (sweep) and RUN.
REQ-021 INIT SHALL hold counter cnt; on each rising edge with iRST_N high, write register cnt with its init value (SP_INIT for SP_INDEX, else 0), then increment cnt.
REQ-022 On the edge writing index 2^ADDR_WIDTH-1, state SHALL become RUN and oReady SHALL be 1 from that edge; total sweep is exactly 2^ADDR_WIDTH cycles.
REQ-023 In INIT, iWriteEn and iReserve SHALL be ignored, oReadData SHALL be all zeros, oReadBusy SHALL be all zeros.
REQ-024 In RUN, a write with iWriteEn=1 and iWriteAddr!=0 SHALL update the register at the rising edge; writes to index 0 SHALL be discarded.
REQ-025 Read ports SHALL be combinational; index 0 SHALL always return 0.
REQ-026 With BYPASS=1, a port whose address equals a valid (non-zero, enabled, RUN) write address SHALL return iWriteData in the same cycle; with BYPASS=0 it SHALL return the stored value.
REQ-027 Scoreboard: one pending bit per register; iReserve=1 in RUN with iReserveAddr!=0 SHALL set the bit at the edge.
REQ-028 A valid write SHALL clear the pending bit of its index at the edge.
REQ-029 Reserve and write to the same index in the same cycle: reserve SHALL win (bit ends set, data still written).
REQ-030 oReadBusy[p] SHALL equal the pending bit of port p's index, except SHALL be 0 when BYPASS=1 and the same-cycle write forwards to that port; index 0 is never busy.
REQ-031 All read ports SHALL be independent; any ports may address the same index.
REQ-032 oDisp SHALL register the value of iDispSelect (no bypass) each edge; 0 in INIT.

Reset
REQ-033 iRST_N low at an edge SHALL force state INIT, cnt=0, all pending bits 0, oReady=0, oDisp=0, regardless of current state, including mid-sweep.
REQ-034 Register contents are not cleared by the reset edge itself; they SHALL be rewritten by the subsequent sweep.

Verification
REQ-035 Release reset, ADDR_WIDTH=5 -> oReady=0 for 31 edges, 1 after the 32nd; read index 2 -> 32'h1000_3FFC, all others 0.
REQ-036 RUN, write 5 <- 32'hDEADBEEF while port 0 reads 5, BYPASS=1 -> port 0 shows DEADBEEF same cycle; BYPASS=0 -> old value, DEADBEEF next cycle.
REQ-037 Write 0 <- 32'hFFFFFFFF, reserve 0 -> reads of index 0 return 0, oReadBusy=0.
REQ-038 Reserve 7, then read 7 -> busy=1; write 7 <- 32'h55 -> busy=0 after edge; reserve+write 7 same cycle -> busy stays 1, data 32'h55 stored.
REQ-039 Assert iRST_N low at sweep cycle 10 -> oReady=0, sweep restarts, oReady rises exactly 32 edges after release.
REQ-040 NUM_READ=3, all ports address index 9 while writing 9 -> all three ports return the write data; oDisp(9) shows it one cycle later.
